// File: rtl/am_sample_scheduler_pkg.sv
// Shared types and helpers for the AM sample scheduler: FSM state encoding
// and the mid-scale carrier level substituted whenever no sample is due.
package am_sample_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_t;

    function automatic int mid_level(input int pwm_steps);
        return pwm_steps / 2;
    endfunction

endpackage

// File: rtl/am_sample_scheduler_fifo.sv
// Small synchronous sample FIFO with a combinational head and an occupancy count.
module sample_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_level;

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + (PW+1)'(1);
                2'b01:   r_level <= r_level - (PW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage write; a full push is only issued alongside a pop, so the
    // overwritten slot is the head being read out in the same cycle.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == (PW+1)'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/am_sample_scheduler.sv
// Releases one buffered audio sample per PWM frame to the AM modulator,
// priming the FIFO first and substituting mid-scale on starvation.
module am_sample_scheduler
    import am_sample_scheduler_pkg::*;
#(
    parameter int PWM_STEPS     = 16,
    parameter int CLKS_PER_STEP = 2,
    parameter int SAMPLE_W      = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int PRIME_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [SAMPLE_W-1:0]           mod_level,
    output logic                          mod_load,
    output logic [1:0]                    state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underruns
);

    localparam int FRAME = PWM_STEPS * CLKS_PER_STEP;
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SAMPLE_W-1:0] MID       = SAMPLE_W'(mid_level(PWM_STEPS));
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(FRAME - 1);
    localparam logic [LVL_W-1:0]    PRIME_LVL = LVL_W'(PRIME_LEVEL);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_mod_level;
    logic                r_mod_load;
    logic [15:0]         r_underruns;

    logic                w_fb;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [SAMPLE_W-1:0] w_head;
    logic [LVL_W-1:0]    w_level;

    // Frame boundaries are ignored once enable drops, since that edge goes to IDLE.
    assign w_fb   = enable && (r_state != ST_IDLE) && (r_cnt == CNT_LAST);
    assign w_pop  = w_fb && (((r_state == ST_RUN) && !w_empty) ||
                             ((r_state == ST_PRIME) && (w_level >= PRIME_LVL)));
    assign w_push = s_valid && !rst && (!w_full || w_pop);
    assign s_ready = !w_full && !rst;

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Scheduler FSM, frame counter and registered modulator outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mod_level <= MID;
            r_mod_load  <= 1'b0;
            r_underruns <= 16'd0;
        end else if (!enable) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mod_level <= MID;
            r_mod_load  <= 1'b0;
        end else begin
            r_mod_load <= w_fb;
            r_cnt      <= ((r_state == ST_IDLE) || (r_cnt == CNT_LAST)) ? '0 : r_cnt + CNT_W'(1);
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_PRIME;
                    r_mod_level <= MID;
                end
                ST_PRIME: begin
                    if (w_fb) begin
                        if (w_pop) begin
                            r_state     <= ST_RUN;
                            r_mod_level <= w_head;
                        end else begin
                            r_mod_level <= MID;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fb) begin
                        if (w_pop) begin
                            r_mod_level <= w_head;
                        end else begin
                            r_state     <= ST_UNDERRUN;
                            r_mod_level <= MID;
                            if (r_underruns != 16'hFFFF) r_underruns <= r_underruns + 16'd1;
                        end
                    end
                end
                ST_UNDERRUN: begin
                    r_state <= ST_PRIME;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mod_level <= MID;
                end
            endcase
        end
    end

    assign mod_level  = r_mod_level;
    assign mod_load   = r_mod_load;
    assign state      = r_state;
    assign fifo_level = w_level;
    assign underruns  = r_underruns;

endmodule
